mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL use one clock, clk, and a synchronous, active-high reset, reset.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- op  in  7  Instr[6:0]
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0=PC, 1=ALUOut as memory address
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1
- ALUSrcB  out  2  00=RD2/WD, 01=ImmExt, 10=constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- halted  out  1  illegal opcode trapped

Function
REQ-003 The FSM states SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, HALT. The state register SHALL be the only sequential element.
REQ-004 Transitions SHALL be:
- FETCH->DECODE
- DECODE->MEMADR for lw (0000011) and sw (0100011)
- DECODE->EXECR for 0110011
- DECODE->EXECI for 0010011
- DECODE->BEQ for 1100011
- DECODE->JAL for 1101111
- DECODE->HALT for any other op
- MEMADR->MEMREAD (lw) or MEMWRITE (sw)
- MEMREAD->MEMWB
- EXECR, EXECI, JAL->ALUWB
- MEMWB, MEMWRITE, ALUWB, BEQ->FETCH
- HALT->HALT
REQ-005 State outputs SHALL be, with every unlisted enable 0 and unlisted selects 00:
- FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PC update
- DECODE: ALUSrcA=01, ALUSrcB=01
- MEMADR and EXECI: ALUSrcA=10, ALUSrcB=01
- MEMREAD: AdrSrc=1
- MEMWB: ResultSrc=01, RegWrite=1
- MEMWRITE: AdrSrc=1, MemWrite=1
- EXECR: ALUSrcA=10
- ALUWB: RegWrite=1
- BEQ: ALUSrcA=10, subtract, branch
- JAL: ALUSrcA=01, ALUSrcB=10, PC update
- HALT: halted=1
REQ-006 PCWrite SHALL equal (PC update) OR (branch AND zero), combinationally.
REQ-007 ALUControl SHALL be add (000) in FETCH, DECODE, MEMADR and JAL, and sub (001) in BEQ. In EXECR and EXECI it SHALL be decoded from funct3:
- 000: sub if op[5]&funct7b5, else add
- 010: slt
- 110: or
- 111: and
- other: add
REQ-008 ImmSrc SHALL be decoded from op in every state: lw/I-type 00, sw 01, beq 10, jal 11, other 00.
REQ-009 Each instruction SHALL take FETCH+DECODE plus: lw 3 states, sw 2, R/I 2, beq 1, jal 2. Total cycles: lw 5, sw/R/I/jal 4, beq 3, with zero wait states.

Reset
REQ-010 A reset sampled high at a rising edge SHALL force the state to FETCH, and SHALL clear halted, including mid-instruction and from HALT.
REQ-011 While reset=1, PCWrite, IRWrite, RegWrite and MemWrite SHALL be 0, regardless of state.

Configuration
REQ-012 Macro MC_CTRL_MEM_WAIT_EN SHALL enable memory wait states.
- Defined: FETCH, MEMREAD and MEMWRITE hold while mem_ready=0.
  - In FETCH, IRWrite and PCWrite assert only in the mem_ready=1 cycle.
  - In MEMWRITE, MemWrite stays 1 until the mem_ready=1 cycle, then the FSM advances.
- Undefined: mem_ready SHALL be ignored and every state SHALL last one cycle.

Verification
REQ-013 lw (op 0000011), no waits -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 only in cycle 5; ResultSrc=01 there.
REQ-014 beq (op 1100011), zero=1 -> PCWrite=1 in FETCH and BEQ; ALUControl=001 in BEQ; with zero=0 -> PCWrite=0 in BEQ.
REQ-015 R-type, funct3=000, funct7b5=1 -> ALUControl=001 in EXECR; same with op 0010011 -> ALUControl=000 in EXECI.
REQ-016 With MC_CTRL_MEM_WAIT_EN: sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, then FETCH; without the macro -> MemWrite=1 for 1 cycle.
REQ-017 op=0000000 -> HALT, halted=1, all enables 0 indefinitely; reset=1 for one edge -> FETCH, halted=0.
REQ-018 reset asserted in MEMREAD -> next state FETCH, no RegWrite pulse issued for the aborted lw.

Source files
------------

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller
// Description : Multicycle RISC-V (RV32I subset) main controller. A 12-state
//               FSM sequences lw, sw, R-type, I-type ALU, beq and jal through
//               the shared-ALU datapath. Unknown opcodes trap into HALT.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               op/funct3/funct7b5- instruction fields for decode
//               zero              - ALU zero flag (branch resolution)
//               mem_ready         - memory handshake (wait-state build only)
//               PCWrite..ImmSrc   - datapath enables and mux selects
//               halted            - illegal opcode trapped
// Config      : define MC_CTRL_MEM_WAIT_EN to let FETCH, MEMREAD and MEMWRITE
//               stall while mem_ready=0; otherwise mem_ready is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       halted
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_HALT     = 4'd11;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

`ifdef MC_CTRL_MEM_WAIT_EN
    localparam logic C_WAIT_EN = 1'b1;
`else
    localparam logic C_WAIT_EN = 1'b0;
`endif

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       w_mem_stall;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_write;

    // Memory-facing states hold while the memory has not completed.
    assign w_mem_stall = C_WAIT_EN & ~mem_ready;

    // ------------------------------------------------------------------
    // State register (the only sequential element)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:    w_next_state = w_mem_stall ? S_FETCH : S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXECR;
                    OP_I:         w_next_state = S_EXECI;
                    OP_BEQ:       w_next_state = S_BEQ;
                    OP_JAL:       w_next_state = S_JAL;
                    default:      w_next_state = S_HALT;
                endcase
            end
            S_MEMADR:   w_next_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next_state = w_mem_stall ? S_MEMREAD : S_MEMWB;
            S_MEMWRITE: w_next_state = w_mem_stall ? S_MEMWRITE : S_FETCH;
            S_EXECR,
            S_EXECI,
            S_JAL:      w_next_state = S_ALUWB;
            S_MEMWB,
            S_ALUWB,
            S_BEQ:      w_next_state = S_FETCH;
            S_HALT:     w_next_state = S_HALT;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUControl  = 3'b000;
        halted      = 1'b0;

        case (r_state)
            S_FETCH: begin
                // IR load and PC+4 only on the cycle the fetch completes.
                w_ir_write  = ~w_mem_stall;
                w_pc_update = ~w_mem_stall;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR,
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            S_ALUWB: w_reg_write = 1'b1;
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = 3'b001;
                w_branch   = 1'b1;
            end
            S_JAL: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    // Architectural enables are suppressed while reset is held so a
    // reset arriving mid-instruction cannot commit any partial state.
    assign PCWrite  = ~reset & (w_pc_update | (w_branch & zero));
    assign IRWrite  = ~reset & w_ir_write;
    assign RegWrite = ~reset & w_reg_write;
    assign MemWrite = ~reset & w_mem_write;

    // Immediate format follows the opcode regardless of state.
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_controller
// Description : Cycle-by-cycle directed vectors for mc_controller. Each
//               record holds the inputs for one cycle and the hand-derived
//               outputs expected for the state the FSM occupies that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic       halted;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    //                ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0], halted}
    localparam logic [11:0] P_RST   = 12'b0_0_0_0_0_10_00_10_0;
    localparam logic [11:0] P_FETCH = 12'b1_0_0_1_0_10_00_10_0;
    localparam logic [11:0] P_DEC   = 12'b0_0_0_0_0_00_01_01_0;
    localparam logic [11:0] P_ADR   = 12'b0_0_0_0_0_00_10_01_0;
    localparam logic [11:0] P_MRD   = 12'b0_1_0_0_0_00_00_00_0;
    localparam logic [11:0] P_MWB   = 12'b0_0_0_0_1_01_00_00_0;
    localparam logic [11:0] P_MWR   = 12'b0_1_1_0_0_00_00_00_0;
    localparam logic [11:0] P_EXR   = 12'b0_0_0_0_0_00_10_00_0;
    localparam logic [11:0] P_AWB   = 12'b0_0_0_0_1_00_00_00_0;
    localparam logic [11:0] P_BEQT  = 12'b1_0_0_0_0_00_10_00_0;
    localparam logic [11:0] P_BEQN  = 12'b0_0_0_0_0_00_10_00_0;
    localparam logic [11:0] P_JAL   = 12'b1_0_0_0_0_00_01_10_0;
    localparam logic [11:0] P_HALT  = 12'b0_0_0_0_0_00_00_00_1;
    localparam logic [11:0] P_NONE  = 12'b0_0_0_0_0_00_00_00_0;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b0000000;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic        rdy;
        logic [11:0] ctl;
        logic [2:0]  alu;
        logic [1:0]  imm;
    } vec_t;

    vec_t vq[$];
    int   n_tests;
    int   n_fail;

    task automatic v(input logic r, input logic [6:0] o, input logic [2:0] f,
                     input logic f7, input logic zz, input logic rd,
                     input logic [11:0] c, input logic [2:0] a, input logic [1:0] im);
        vec_t t;
        t.rst = r; t.op = o; t.f3 = f; t.f7 = f7; t.z = zz; t.rdy = rd;
        t.ctl = c; t.alu = a; t.imm = im;
        vq.push_back(t);
    endtask

    initial begin
        logic [11:0] act;
        n_tests = 0;
        n_fail  = 0;

        // Reset held in FETCH: enables suppressed, selects still visible
        v(1, LW, 3'b000, 0, 0, 1, P_RST,   3'b000, 2'b00);
        // lw: 5 cycles, RegWrite only in the 5th
        v(0, LW, 3'b000, 0, 0, 1, P_FETCH, 3'b000, 2'b00);
        v(0, LW, 3'b000, 0, 0, 1, P_DEC,   3'b000, 2'b00);
        v(0, LW, 3'b000, 0, 0, 1, P_ADR,   3'b000, 2'b00);
        v(0, LW, 3'b000, 0, 0, 1, P_MRD,   3'b000, 2'b00);
        v(0, LW, 3'b000, 0, 0, 1, P_MWB,   3'b000, 2'b00);
        // sw: 4 cycles
        v(0, SW, 3'b010, 0, 0, 1, P_FETCH, 3'b000, 2'b01);
        v(0, SW, 3'b010, 0, 0, 1, P_DEC,   3'b000, 2'b01);
        v(0, SW, 3'b010, 0, 0, 1, P_ADR,   3'b000, 2'b01);
        v(0, SW, 3'b010, 0, 0, 1, P_MWR,   3'b000, 2'b01);
        // R-type sub
        v(0, RT, 3'b000, 1, 0, 1, P_FETCH, 3'b000, 2'b00);
        v(0, RT, 3'b000, 1, 0, 1, P_DEC,   3'b000, 2'b00);
        v(0, RT, 3'b000, 1, 0, 1, P_EXR,   3'b001, 2'b00);
        v(0, RT, 3'b000, 1, 0, 1, P_AWB,   3'b000, 2'b00);
        // I-type funct3=000 with funct7b5=1 is still add
        v(0, IT, 3'b000, 1, 0, 1, P_FETCH, 3'b000, 2'b00);
        v(0, IT, 3'b000, 1, 0, 1, P_DEC,   3'b000, 2'b00);
        v(0, IT, 3'b000, 1, 0, 1, P_ADR,   3'b000, 2'b00);
        v(0, IT, 3'b000, 1, 0, 1, P_AWB,   3'b000, 2'b00);
        // I-type slt
        v(0, IT, 3'b010, 0, 0, 1, P_FETCH, 3'b000, 2'b00);
        v(0, IT, 3'b010, 0, 0, 1, P_DEC,   3'b000, 2'b00);
        v(0, IT, 3'b010, 0, 0, 1, P_ADR,   3'b101, 2'b00);
        v(0, IT, 3'b010, 0, 0, 1, P_AWB,   3'b000, 2'b00);
        // R-type or; reset during ALUWB must block RegWrite
        v(0, RT, 3'b110, 0, 0, 1, P_FETCH, 3'b000, 2'b00);
        v(0, RT, 3'b110, 0, 0, 1, P_DEC,   3'b000, 2'b00);
        v(0, RT, 3'b110, 0, 0, 1, P_EXR,   3'b011, 2'b00);
        v(1, RT, 3'b110, 0, 0, 1, P_NONE,  3'b000, 2'b00);
        // R-type and
        v(0, RT, 3'b111, 0, 0, 1, P_FETCH, 3'b000, 2'b00);
        v(0, RT, 3'b111, 0, 0, 1, P_DEC,   3'b000, 2'b00);
        v(0, RT, 3'b111, 0, 0, 1, P_EXR,   3'b010, 2'b00);
        v(0, RT, 3'b111, 0, 0, 1, P_AWB,   3'b000, 2'b00);
        // R-type unlisted funct3 defaults to add
        v(0, RT, 3'b001, 1, 0, 1, P_FETCH, 3'b000, 2'b00);
        v(0, RT, 3'b001, 1, 0, 1, P_DEC,   3'b000, 2'b00);
        v(0, RT, 3'b001, 1, 0, 1, P_EXR,   3'b000, 2'b00);
        v(0, RT, 3'b001, 1, 0, 1, P_AWB,   3'b000, 2'b00);
        // beq taken: 3 cycles, PCWrite in FETCH and BEQ
        v(0, BEQ, 3'b000, 0, 1, 1, P_FETCH, 3'b000, 2'b10);
        v(0, BEQ, 3'b000, 0, 1, 1, P_DEC,   3'b000, 2'b10);
        v(0, BEQ, 3'b000, 0, 1, 1, P_BEQT,  3'b001, 2'b10);
        // beq not taken
        v(0, BEQ, 3'b000, 0, 0, 1, P_FETCH, 3'b000, 2'b10);
        v(0, BEQ, 3'b000, 0, 0, 1, P_DEC,   3'b000, 2'b10);
        v(0, BEQ, 3'b000, 0, 0, 1, P_BEQN,  3'b001, 2'b10);
        // jal
        v(0, JAL, 3'b000, 0, 0, 1, P_FETCH, 3'b000, 2'b11);
        v(0, JAL, 3'b000, 0, 0, 1, P_DEC,   3'b000, 2'b11);
        v(0, JAL, 3'b000, 0, 0, 1, P_JAL,   3'b000, 2'b11);
        v(0, JAL, 3'b000, 0, 0, 1, P_AWB,   3'b000, 2'b11);
`ifdef MC_CTRL_MEM_WAIT_EN
        // Stalled fetch, then sw whose write stalls 3 cycles (MemWrite x4)
        v(0, SW, 3'b010, 0, 0, 0, P_RST,   3'b000, 2'b01);
        v(0, SW, 3'b010, 0, 0, 1, P_FETCH, 3'b000, 2'b01);
        v(0, SW, 3'b010, 0, 0, 1, P_DEC,   3'b000, 2'b01);
        v(0, SW, 3'b010, 0, 0, 1, P_ADR,   3'b000, 2'b01);
        v(0, SW, 3'b010, 0, 0, 0, P_MWR,   3'b000, 2'b01);
        v(0, SW, 3'b010, 0, 0, 0, P_MWR,   3'b000, 2'b01);
        v(0, SW, 3'b010, 0, 0, 0, P_MWR,   3'b000, 2'b01);
        v(0, SW, 3'b010, 0, 0, 1, P_MWR,   3'b000, 2'b01);
`else
        // mem_ready low is ignored: every state lasts one cycle
        v(0, SW, 3'b010, 0, 0, 0, P_FETCH, 3'b000, 2'b01);
        v(0, SW, 3'b010, 0, 0, 0, P_DEC,   3'b000, 2'b01);
        v(0, SW, 3'b010, 0, 0, 0, P_ADR,   3'b000, 2'b01);
        v(0, SW, 3'b010, 0, 0, 0, P_MWR,   3'b000, 2'b01);
`endif
        // lw aborted by reset in MEMREAD: next is FETCH, never MEMWB
        v(0, LW, 3'b000, 0, 0, 1, P_FETCH, 3'b000, 2'b00);
        v(0, LW, 3'b000, 0, 0, 1, P_DEC,   3'b000, 2'b00);
        v(0, LW, 3'b000, 0, 0, 1, P_ADR,   3'b000, 2'b00);
        v(1, LW, 3'b000, 0, 0, 1, P_MRD,   3'b000, 2'b00);
        // Illegal opcode traps and stays trapped
        v(0, BAD, 3'b000, 0, 0, 1, P_FETCH, 3'b000, 2'b00);
        v(0, BAD, 3'b000, 0, 0, 1, P_DEC,   3'b000, 2'b00);
        v(0, BAD, 3'b000, 0, 1, 1, P_HALT,  3'b000, 2'b00);
        v(0, JAL, 3'b000, 0, 1, 0, P_HALT,  3'b000, 2'b11);
        v(0, LW,  3'b000, 0, 0, 1, P_HALT,  3'b000, 2'b00);
        // One reset edge leaves HALT
        v(1, LW,  3'b000, 0, 0, 1, P_HALT,  3'b000, 2'b00);
        v(0, LW,  3'b000, 0, 0, 1, P_FETCH, 3'b000, 2'b00);
        v(0, LW,  3'b000, 0, 0, 1, P_DEC,   3'b000, 2'b00);

        // Bring the FSM to a known state before the table starts
        reset = 1'b1; op = LW; funct3 = 3'b000; funct7b5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state: FETCH selects, all enables and halted low
        @(negedge clk);
        #1;
        n_tests++;
        if (PCWrite !== 1'b0 || IRWrite !== 1'b0 || RegWrite !== 1'b0 ||
            MemWrite !== 1'b0 || halted !== 1'b0 ||
            ALUSrcB !== 2'b10 || ResultSrc !== 2'b10) begin
            n_fail++;
            $display("FAIL reset-state: PCWrite=%b IRWrite=%b RegWrite=%b MemWrite=%b halted=%b ALUSrcB=%b ResultSrc=%b",
                     PCWrite, IRWrite, RegWrite, MemWrite, halted, ALUSrcB, ResultSrc);
        end

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            reset     = vq[i].rst;
            op        = vq[i].op;
            funct3    = vq[i].f3;
            funct7b5  = vq[i].f7;
            zero      = vq[i].z;
            mem_ready = vq[i].rdy;
            #1;
            act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                   ResultSrc, ALUSrcA, ALUSrcB, halted};
            n_tests++;
            if (act !== vq[i].ctl || ALUControl !== vq[i].alu || ImmSrc !== vq[i].imm) begin
                n_fail++;
                $display("FAIL step%0d: got ctl=%b alu=%b imm=%b, expected ctl=%b alu=%b imm=%b",
                         i, act, ALUControl, ImmSrc, vq[i].ctl, vq[i].alu, vq[i].imm);
            end
        end

        // lw left in DECODE: next cycle must be MEMADR
        @(negedge clk);
        reset = 1'b0; op = LW; funct3 = 3'b000; funct7b5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b1;
        #1;
        act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, halted};
        n_tests++;
        if (act !== P_ADR || ALUControl !== 3'b000) begin
            n_fail++;
            $display("FAIL memadr-after-decode: got ctl=%b alu=%b, expected ctl=%b alu=%b",
                     act, ALUControl, P_ADR, 3'b000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
